seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
- Runtime-programmable serial bit-pattern detector. Successor to the fixed two-pattern detector FSM.
- Pattern, don't-care mask, length and overlap mode are loaded through a config strobe instead of being hard-coded as states.
- Emits a one-cycle match flag and keeps a saturating match counter.
- Sits on a serial bit stream between the deserialiser front end and the control logic.

Parameters:
- PAT_W, 8: maximum pattern length in bits (2..32).
- CNT_W, 8: match counter width (2..32).
- LEN_W, $clog2(PAT_W+1): width of cfg_len. Derived; do not override.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din_valid  input  1  din carries a new bit this cycle.
- din  input  1  serial data bit.
- cfg_we  input  1  load configuration this cycle.
- cfg_pattern  input  PAT_W  pattern; bit 0 = most recent bit, bit len-1 = oldest.
- cfg_mask  input  PAT_W  1 = compare this bit, 0 = don't care.
- cfg_len  input  LEN_W  active pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed.
- cnt_clr  input  1  clear match_cnt and cnt_sat.
- flag  output  1  one-cycle match pulse, registered.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  sticky; set when match_cnt reaches all-ones.

Behaviour:
- Reset (rst_n low at a clock edge):
  - flag=0, match_cnt=0, cnt_sat=0.
  - Shadow config cleared: pattern=0, mask=0, len=0, overlap=0. Detection is disabled until the first cfg_we.
  - History register hist=0; fill counter fill=0.
- Config load (cfg_we=1):
  - Captures cfg_* into shadow registers.
  - Clears hist and fill. flag is 0 next cycle.
  - Does not touch match_cnt or cnt_sat.
  - If din_valid=1 in the same cycle, the bit is dropped.
- Length rules:
  - cfg_len > PAT_W is clamped to PAT_W at load.
  - len=0 disables detection: flag is never set and the counter never increments.
- Bit accept (din_valid=1, cfg_we=0):
  - hist <= {hist[PAT_W-2:0], din}.
  - fill <= min(fill+1, len).
- Match condition, evaluated on the post-shift hist and fill:
  - fill_next == len, len != 0, and
  - ((hist_next ^ pattern) & mask & lenmask) == 0, where lenmask has the low len bits set.
- Latency: flag=1 in the cycle after the clock edge that accepted the completing bit. It lasts exactly one cycle; otherwise flag=0.
- Bubble (din_valid=0): hist and fill hold; flag=0.
- Overlap mode:
  - overlap=1: fill stays saturated at len, so consecutive matches may share bits.
  - overlap=0: fill is forced to 0 on a match, so the next match needs len fresh bits.
- Counter:
  - A match increments match_cnt. At all-ones it holds, and cnt_sat becomes 1 and stays set.
  - cnt_clr=1 forces match_cnt=0 and cnt_sat=0, and wins over a same-cycle match. flag still pulses in that case.
- Reset mid-stream discards all partial history. Bits accepted before reset never contribute to a match.
- All-zero mask with len>0: every accepted bit with fill_next==len is a match.

Optional Feature:
- Macro: SEQ_DETECT_DUAL_EN.
- Defined:
  - Adds a second comparator channel B, sharing hist, fill, len and overlap.
  - Extra ports: cfg_pattern_b (input, PAT_W), cfg_mask_b (input, PAT_W), flag_b (output, 1, reset 0). Channel B config loads on the same cfg_we.
  - flag_b follows the same timing rules as flag.
  - match_cnt counts a cycle in which A or B (or both) matches as one match.
  - With overlap=0, fill clears if either channel matches.
- Not defined: ports and logic are absent; single-channel behaviour only.

Test Plan:
- PAT_W=8. Load pattern=4'b1101, mask=4'hF, len=4, overlap=1. Stream 1,1,0,1,1,0,1 (all valid) -> flag pulses after bits 4 and 7; match_cnt=2.
- Same config with overlap=0, same stream -> flag only after bit 4; match_cnt=1.
- pattern=4'b1001, mask=4'b1011, len=4. Stream 1,1,0,1 -> flag after bit 4 (bit 2 is don't-care). Stream 1,0,1,1 -> no flag.
- CNT_W=2. Pattern 2'b11, len=2, overlap=1, six consecutive 1s -> five matches; match_cnt holds at 3, cnt_sat=1. Then cnt_clr=1 -> match_cnt=0, cnt_sat=0.
- Pattern 1101, len=4. Feed 1,1,0, then rst_n=0 for one cycle, then cfg reload and bit 1 -> no flag. Also insert din_valid=0 gaps inside 1,1,0,1 -> flag still after the 4th valid bit.
- len=0, 16 random bits -> flag never set, match_cnt=0. Then cfg_we together with din_valid=1 -> that bit is ignored (hist=0, fill=0).

Source files
------------

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial bit-pattern detector.
// Pattern, don't-care mask, length and overlap mode are loaded through a
// config strobe into shadow registers. A match raises a one-cycle registered
// flag and bumps a saturating match counter with a sticky saturation bit.
// Optional macro SEQ_DETECT_DUAL_EN adds a second comparator channel (B)
// that shares the history, fill count, length and overlap mode.
module seq_detect_prog #(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
`ifdef SEQ_DETECT_DUAL_EN
    input  logic [PAT_W-1:0] cfg_pattern_b,
    input  logic [PAT_W-1:0] cfg_mask_b,
    output logic             flag_b,
`endif
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Shadow configuration
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] mask_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;

    // Stream state: hist[0] is the most recent accepted bit
    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;

    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_next;
    logic [PAT_W-1:0] lenmask;
    logic             accept;
    logic             hit_a;
    logic             match_a;
    logic             match_any;
    logic [CNT_W-1:0] cnt_inc;

`ifdef SEQ_DETECT_DUAL_EN
    logic [PAT_W-1:0] pat_b_q;
    logic [PAT_W-1:0] mask_b_q;
    logic             hit_b;
    logic             match_b;
`endif

    // Post-shift history/fill and per-channel compare against the shadow config
    always_comb begin
        accept    = din_valid && !cfg_we;
        hist_next = {hist_q[PAT_W-2:0], din};
        // fill <= len always holds, so fill+1 never exceeds PAT_W here
        fill_next = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
        lenmask   = '0;
        for (int i = 0; i < PAT_W; i++)
            lenmask[i] = (i < int'(len_q));
        hit_a     = (len_q != '0) && (fill_next == len_q) &&
                    (((hist_next ^ pat_q) & mask_q & lenmask) == '0);
        match_a   = accept && hit_a;
`ifdef SEQ_DETECT_DUAL_EN
        hit_b     = (len_q != '0) && (fill_next == len_q) &&
                    (((hist_next ^ pat_b_q) & mask_b_q & lenmask) == '0);
        match_b   = accept && hit_b;
        match_any = match_a || match_b;
`else
        match_any = match_a;
`endif
        cnt_inc   = match_cnt + 1'b1;
    end

    // Config shadow load; an oversize length is clamped to PAT_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q  <= '0;
            mask_q <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
        end else if (cfg_we) begin
            pat_q  <= cfg_pattern;
            mask_q <= cfg_mask;
            len_q  <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            ovl_q  <= cfg_overlap;
        end
    end

`ifdef SEQ_DETECT_DUAL_EN
    // Channel B shadow config loads on the same strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_b_q  <= '0;
            mask_b_q <= '0;
        end else if (cfg_we) begin
            pat_b_q  <= cfg_pattern_b;
            mask_b_q <= cfg_mask_b;
        end
    end
`endif

    // History shift and fill tracking; a config load restarts the stream and
    // a non-overlapping match demands a fresh run of len bits
    always_ff @(posedge clk) begin
        if (!rst_n || cfg_we) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (accept) begin
            hist_q <= hist_next;
            fill_q <= (match_any && !ovl_q) ? '0 : fill_next;
        end
    end

    // Registered one-cycle match flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag   <= 1'b0;
`ifdef SEQ_DETECT_DUAL_EN
            flag_b <= 1'b0;
`endif
        end else begin
            flag   <= match_a;
`ifdef SEQ_DETECT_DUAL_EN
            flag_b <= match_b;
`endif
        end
    end

    // Saturating match counter; clear beats a same-cycle match
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (match_any && match_cnt != CNT_MAX) begin
            match_cnt <= cnt_inc;
            if (cnt_inc == CNT_MAX)
                cnt_sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog. Two instances share the stimulus:
// u_dut (CNT_W=8) for general checks, u_sat (CNT_W=2) for saturation.
module tb_seq_detect_prog;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [PAT_W-1:0] cfg_mask = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             flag, flag2;
    logic [7:0]       match_cnt;
    logic [1:0]       match_cnt2;
    logic             cnt_sat, cnt_sat2;
`ifdef SEQ_DETECT_DUAL_EN
    logic             flag_b, flag_b2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
`ifdef SEQ_DETECT_DUAL_EN
        .cfg_pattern_b(cfg_pattern), .cfg_mask_b(cfg_mask), .flag_b(flag_b),
`endif
        .flag(flag), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
`ifdef SEQ_DETECT_DUAL_EN
        .cfg_pattern_b(cfg_pattern), .cfg_mask_b(cfg_mask), .flag_b(flag_b2),
`endif
        .flag(flag2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given bit; outputs are sampled 1 time unit later
    task automatic step(input logic v, input logic d);
        din_valid = v;
        din       = d;
        @(posedge clk); #1;
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    // Load config (also clears counters); flag must be low the next cycle
    task automatic load(input logic [7:0] pat, input logic [7:0] msk,
                        input logic [LEN_W-1:0] len, input logic ovl);
        cfg_pattern = pat;
        cfg_mask    = msk;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_we      = 1'b1;
        cnt_clr     = 1'b1;
        @(posedge clk); #1;
        cfg_we      = 1'b0;
        cnt_clr     = 1'b0;
        chk("cfg_flag", {31'd0, flag}, 32'd0);
    endtask

    // Feed n valid bits (bits[n-1] first); exp[n-1-k] is the flag after bit k
    task automatic run(input string tag, input int n, input logic [31:0] bits,
                       input logic [31:0] exp);
        for (int k = 0; k < n; k++) begin
            step(1'b1, bits[n-1-k]);
            chk($sformatf("%s_b%0d", tag, k + 1), {31'd0, flag}, {31'd0, exp[n-1-k]});
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flag", {31'd0, flag}, 32'd0);
        chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
        chk("rst_sat", {31'd0, cnt_sat}, 32'd0);
        rst_n = 1'b1;

        // Detection disabled until first load
        step(1'b1, 1'b1);
        chk("pre_cfg_flag", {31'd0, flag}, 32'd0);

        // Overlapping 1101
        load(8'b1101, 8'h0F, 4'd4, 1'b1);
        run("ovl1", 7, 32'b1101101, 32'b0001001);
        chk("ovl1_cnt", {24'd0, match_cnt}, 32'd2);

        // Non-overlapping 1101
        load(8'b1101, 8'h0F, 4'd4, 1'b0);
        run("ovl0", 7, 32'b1101101, 32'b0001000);
        chk("ovl0_cnt", {24'd0, match_cnt}, 32'd1);

        // Don't-care on bit 2
        load(8'b1001, 8'b1011, 4'd4, 1'b1);
        run("dc_hit", 4, 32'b1101, 32'b0001);
        load(8'b1001, 8'b1011, 4'd4, 1'b1);
        run("dc_miss", 4, 32'b1011, 32'b0000);
        chk("dc_cnt", {24'd0, match_cnt}, 32'd0);

        // Saturation on the 2-bit counter instance
        load(8'b11, 8'h03, 4'd2, 1'b1);
        run("sat", 6, 32'b111111, 32'b011111);
        chk("sat_cnt2", {30'd0, match_cnt2}, 32'd3);
        chk("sat_sat2", {31'd0, cnt_sat2}, 32'd1);
        chk("sat_cnt8", {24'd0, match_cnt}, 32'd5);
        chk("sat_sat8", {31'd0, cnt_sat}, 32'd0);
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
        cnt_clr = 1'b0;
        chk("clr_cnt2", {30'd0, match_cnt2}, 32'd0);
        chk("clr_sat2", {31'd0, cnt_sat2}, 32'd0);
        // Clear beats a same-cycle match; flag still pulses
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        chk("clrwin_flag", {31'd0, flag}, 32'd1);
        chk("clrwin_cnt", {24'd0, match_cnt}, 32'd0);

        // Reset mid-stream discards history and config
        load(8'b1101, 8'h0F, 4'd4, 1'b1);
        run("pre_rst", 3, 32'b110, 32'b000);
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        chk("midrst_flag", {31'd0, flag}, 32'd0);
        chk("midrst_cnt", {24'd0, match_cnt}, 32'd0);
        load(8'b1101, 8'h0F, 4'd4, 1'b1);
        run("post_rst", 1, 32'b1, 32'b0);

        // Bubbles inside 1,1,0,1
        load(8'b1101, 8'h0F, 4'd4, 1'b1);
        run("gap_a", 1, 32'b1, 32'b0);
        step(1'b0, 1'b1);
        chk("gap_bub1", {31'd0, flag}, 32'd0);
        run("gap_b", 1, 32'b1, 32'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("gap_bub2", {31'd0, flag}, 32'd0);
        run("gap_c", 2, 32'b01, 32'b01);
        step(1'b0, 1'b1);
        chk("gap_after", {31'd0, flag}, 32'd0);

        // All-zero mask, len 3: every bit with full fill matches
        load(8'h00, 8'h00, 4'd3, 1'b1);
        run("mask0", 4, 32'b0110, 32'b0011);

        // Length clamp: 15 -> 8, pattern A5 fed oldest bit first
        load(8'hA5, 8'hFF, 4'd15, 1'b1);
        run("clamp", 8, 32'hA5, 32'h01);

        // len=0 disables detection
        load(8'h00, 8'h00, 4'd0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            chk($sformatf("len0_b%0d", k + 1), {31'd0, flag}, 32'd0);
        end
        chk("len0_cnt", {24'd0, match_cnt}, 32'd0);

        // Bit arriving with cfg_we is dropped: a 1 here followed by 0 would
        // otherwise complete pattern 10
        din_valid = 1'b1;
        din       = 1'b1;
        load(8'b10, 8'h03, 4'd2, 1'b0);
        run("drop", 2, 32'b00, 32'b00);
        chk("drop_cnt", {24'd0, match_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
